// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C target controller.
// Bus state enum, default device address and acknowledge levels.
package i2c_slave_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WRITE     = 3'd3,
    WRITE_ACK = 3'd4,
    READ      = 3'd5,
    READ_ACK  = 3'd6
  } state_t;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h55;
  localparam logic       ACK                = 1'b0;
  localparam logic       NACK               = 1'b1;
  localparam logic [2:0] BIT_LAST           = 3'd7;

endpackage

// File: rtl/i2c_slave_mem.sv
// Byte register file for the I2C target: write on SCL rising edge,
// combinational read, whole array cleared by the async active-low reset.
module i2c_slave_mem
  import i2c_slave_pkg::*;
#(
  parameter int MEM_DEPTH = 16,
  parameter int MEM_AW    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [MEM_AW-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [MEM_AW-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem_r [MEM_DEPTH];

  // Storage array with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C target with 7-bit address and a small byte memory, clocked only by SCL.
// Rising edge samples SDA; falling edge detects START/STOP and moves the FSM.
module i2c_slave_ctrl
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
  parameter int         MEM_DEPTH  = 16,
  parameter int         MEM_AW     = 4
) (
  input  logic i2c_scl,
  input  logic i2c_rst,
  inout  wire  i2c_sda
);

  state_t            state_r, state_s;
  logic [2:0]        bit_cnt_r, bit_cnt_s;
  logic [7:0]        shift_r, shift_s;
  logic [MEM_AW-1:0] ptr_r, ptr_s, ptr_inc_s, rd_addr_s;
  logic              rw_r, rw_s;
  logic              sda_oe_r, sda_oe_s;
  logic              sda_out_r, sda_out_s;
  logic              sda_r, sda_f_s;
  logic              start_s, stop_s, mem_we_s;
  logic [7:0]        rd_data_s;

  function automatic logic [MEM_AW-1:0] ptr_wrap(input logic [MEM_AW-1:0] p);
    if (p == MEM_AW'(MEM_DEPTH - 1)) begin
      return {MEM_AW{1'b0}};
    end else begin
      return p + MEM_AW'(1);
    end
  endfunction

  assign sda_f_s   = i2c_sda;
  assign start_s   = sda_r & ~sda_f_s;
  assign stop_s    = ~sda_r & sda_f_s;
  assign ptr_inc_s = ptr_wrap(ptr_r);
  // In READ_ACK the next byte is fetched ahead of the pointer update.
  assign rd_addr_s = (state_r == READ_ACK) ? ptr_inc_s : ptr_r;
  // The byte is committed only once the falling edge after bit 0 showed no START/STOP.
  assign mem_we_s  = (state_r == WRITE_ACK);
  assign i2c_sda   = sda_oe_r ? sda_out_r : 1'bz;

  i2c_slave_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .MEM_AW    (MEM_AW)
  ) u_mem (
    .clk   (i2c_scl),
    .rst_n (i2c_rst),
    .we    (mem_we_s),
    .waddr (ptr_r),
    .wdata (shift_r),
    .raddr (rd_addr_s),
    .rdata (rd_data_s)
  );

  // SDA sample on SCL rising edge
  always_ff @(posedge i2c_scl or negedge i2c_rst) begin
    if (!i2c_rst) begin
      sda_r <= 1'b0;
    end else begin
      sda_r <= i2c_sda;
    end
  end

  // Falling-edge state, shift, pointer and SDA drive registers
  always_ff @(negedge i2c_scl or negedge i2c_rst) begin
    if (!i2c_rst) begin
      state_r   <= IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      ptr_r     <= {MEM_AW{1'b0}};
      rw_r      <= 1'b0;
      sda_oe_r  <= 1'b0;
      sda_out_r <= 1'b1;
    end else begin
      state_r   <= state_s;
      bit_cnt_r <= bit_cnt_s;
      shift_r   <= shift_s;
      ptr_r     <= ptr_s;
      rw_r      <= rw_s;
      sda_oe_r  <= sda_oe_s;
      sda_out_r <= sda_out_s;
    end
  end

  // Next-state and SDA drive decode; bus conditions override the FSM
  always_comb begin
    state_s   = state_r;
    bit_cnt_s = bit_cnt_r;
    shift_s   = shift_r;
    ptr_s     = ptr_r;
    rw_s      = rw_r;
    sda_oe_s  = sda_oe_r;
    sda_out_s = sda_out_r;
    if (start_s) begin
      state_s   = ADDR;
      bit_cnt_s = 3'd0;
      ptr_s     = {MEM_AW{1'b0}};
      sda_oe_s  = 1'b0;
      sda_out_s = NACK;
    end else if (stop_s) begin
      state_s   = IDLE;
      bit_cnt_s = 3'd0;
      sda_oe_s  = 1'b0;
      sda_out_s = NACK;
    end else begin
      case (state_r)
        IDLE: begin
          sda_oe_s  = 1'b0;
          sda_out_s = NACK;
        end
        ADDR: begin
          shift_s = {shift_r[6:0], sda_r};
          if (bit_cnt_r == BIT_LAST) begin
            bit_cnt_s = 3'd0;
            if (shift_r[6:0] == SLAVE_ADDR) begin
              state_s   = ADDR_ACK;
              rw_s      = sda_r;
              sda_oe_s  = 1'b1;
              sda_out_s = ACK;
            end else begin
              state_s   = IDLE;
              sda_oe_s  = 1'b0;
              sda_out_s = NACK;
            end
          end else begin
            bit_cnt_s = bit_cnt_r + 3'd1;
          end
        end
        ADDR_ACK: begin
          bit_cnt_s = 3'd0;
          if (rw_r) begin
            state_s   = READ;
            shift_s   = rd_data_s;
            sda_oe_s  = 1'b1;
            sda_out_s = rd_data_s[7];
          end else begin
            state_s   = WRITE;
            sda_oe_s  = 1'b0;
            sda_out_s = NACK;
          end
        end
        WRITE: begin
          shift_s = {shift_r[6:0], sda_r};
          if (bit_cnt_r == BIT_LAST) begin
            state_s   = WRITE_ACK;
            bit_cnt_s = 3'd0;
            sda_oe_s  = 1'b1;
            sda_out_s = ACK;
          end else begin
            bit_cnt_s = bit_cnt_r + 3'd1;
          end
        end
        WRITE_ACK: begin
          state_s   = WRITE;
          ptr_s     = ptr_inc_s;
          sda_oe_s  = 1'b0;
          sda_out_s = NACK;
        end
        READ: begin
          if (bit_cnt_r == BIT_LAST) begin
            state_s   = READ_ACK;
            bit_cnt_s = 3'd0;
            sda_oe_s  = 1'b0;
            sda_out_s = NACK;
          end else begin
            bit_cnt_s = bit_cnt_r + 3'd1;
            shift_s   = {shift_r[6:0], 1'b0};
            sda_out_s = shift_r[6];
          end
        end
        READ_ACK: begin
          ptr_s     = ptr_inc_s;
          bit_cnt_s = 3'd0;
          if (sda_r == ACK) begin
            state_s   = READ;
            shift_s   = rd_data_s;
            sda_oe_s  = 1'b1;
            sda_out_s = rd_data_s[7];
          end else begin
            state_s   = IDLE;
            sda_oe_s  = 1'b0;
            sda_out_s = NACK;
          end
        end
        default: begin
          state_s   = IDLE;
          sda_oe_s  = 1'b0;
          sda_out_s = NACK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Self-checking bench for i2c_slave_ctrl: an open-drain bus master drives
// transfers; a model memory feeds a scoreboard of expected read bytes.
module tb_i2c_slave_ctrl;

  localparam logic [7:0] ADDR_W = 8'hAA;
  localparam logic [7:0] ADDR_R = 8'hAB;

  logic scl;
  logic rst;
  logic m_low;
  wire  sda_bus;

  int checks;
  int errors;
  int mptr;
  logic [7:0] model_mem [16];
  logic [7:0] exp_q [$];

  assign sda_bus = m_low ? 1'b0 : 1'bz;
  pullup pu_sda (sda_bus);

  i2c_slave_ctrl dut (
    .i2c_scl (scl),
    .i2c_rst (rst),
    .i2c_sda (sda_bus)
  );

  // One SCL period; master releases for b=1, pulls low for b=0; bus sampled mid-high.
  task automatic clk_bit(input logic b, output logic seen);
    m_low = ~b;
    #25 scl = 1'b1;
    #25 seen = sda_bus;
    #25 scl = 1'b0;
    #25;
  endtask

  task automatic bus_start();
    m_low = 1'b0;
    #25 scl = 1'b1;
    #25 m_low = 1'b1;
    #25 scl = 1'b0;
    #25;
    mptr = 0;
  endtask

  task automatic bus_stop();
    m_low = 1'b1;
    #25 scl = 1'b1;
    #25 m_low = 1'b0;
    #25 scl = 1'b0;
    #25;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic master_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(master_ack, s);
  endtask

  task automatic model_write(input logic [7:0] b);
    model_mem[mptr] = b;
    mptr = (mptr + 1) % 16;
  endtask

  // START, address+W, n bytes; bus left without STOP.
  task automatic write_txn(input int n, input logic [31:0] data,
                           output logic aack, output logic [3:0] dacks);
    dacks = 4'hF;
    bus_start();
    send_byte(ADDR_W, aack);
    for (int i = 0; i < n; i++) begin
      send_byte(data[8*i +: 8], dacks[i]);
      model_write(data[8*i +: 8]);
    end
  endtask

  // (Repeated) START, address+R, n bytes ACKed except the last, then one idle bit and STOP.
  task automatic read_txn(input int n, output logic aack,
                          output logic [31:0] got, output logic rel);
    logic [7:0] d;
    got = 32'h0;
    bus_start();
    send_byte(ADDR_R, aack);
    for (int i = 0; i < n; i++) exp_q.push_back(model_mem[(mptr + i) % 16]);
    for (int i = 0; i < n; i++) begin
      recv_byte((i == n - 1) ? 1'b1 : 1'b0, d);
      got[8*i +: 8] = d;
    end
    mptr = (mptr + n) % 16;
    clk_bit(1'b1, rel);
    bus_stop();
  endtask

  task automatic test_reset();
    logic s;
    logic a;
    logic r;
    logic [31:0] got;
    logic [7:0] exp;
    #10;
    checks++;
    if (sda_bus !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b want 1", sda_bus); end
    #5 rst = 1'b1;
    #10;
    for (int i = 7; i >= 0; i--) clk_bit(ADDR_W[i], s);
    clk_bit(1'b1, s);
    checks++;
    if (s !== 1'b1) begin errors++; $display("FAIL no_start_ack: got %b want 1", s); end
    read_txn(1, a, got, r);
    checks++;
    if (a !== 1'b0) begin errors++; $display("FAIL reset_rd_addr_ack: got %b want 0", a); end
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL reset_mem: got %h, scoreboard empty", got[7:0]);
    end else begin
      exp = exp_q.pop_front();
      if (got[7:0] !== exp) begin errors++; $display("FAIL reset_mem: got %h want %h", got[7:0], exp); end
    end
  endtask

  task automatic test_addr_ack();
    logic a;
    logic s;
    bus_start();
    send_byte(ADDR_W, a);
    checks++;
    if (a !== 1'b0) begin errors++; $display("FAIL addr_ack: got %b want 0", a); end
    clk_bit(1'b1, s);
    checks++;
    if (s !== 1'b1) begin errors++; $display("FAIL addr_ack_release: got %b want 1", s); end
    bus_stop();
  endtask

  task automatic test_write_read();
    logic a;
    logic r;
    logic [3:0] dk;
    logic [31:0] got;
    logic [7:0] exp;
    write_txn(1, 32'h0000_00A5, a, dk);
    checks++;
    if ({a, dk[0]} !== 2'b00) begin errors++; $display("FAIL wr_acks: got %b want 00", {a, dk[0]}); end
    read_txn(1, a, got, r);
    checks++;
    if (a !== 1'b0) begin errors++; $display("FAIL rd_addr_ack: got %b want 0", a); end
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL wr_rd_data: got %b, scoreboard empty", got[7:0]);
    end else begin
      exp = exp_q.pop_front();
      if (got[7:0] !== exp) begin errors++; $display("FAIL wr_rd_data: got %b want %b", got[7:0], exp); end
    end
    checks++;
    if (r !== 1'b1) begin errors++; $display("FAIL rd_nack_release: got %b want 1", r); end
  endtask

  task automatic test_addr_mismatch();
    logic a;
    bus_start();
    send_byte(8'hA8, a);
    checks++;
    if (a !== 1'b1) begin errors++; $display("FAIL mismatch_nack: got %b want 1", a); end
    send_byte(8'h00, a);
    checks++;
    if (a !== 1'b1) begin errors++; $display("FAIL mismatch_ignored: got %b want 1", a); end
    bus_stop();
  endtask

  task automatic test_wrap();
    logic a;
    logic r;
    logic [31:0] got;
    logic [7:0] exp;
    bus_start();
    send_byte(ADDR_W, a);
    checks++;
    if (a !== 1'b0) begin errors++; $display("FAIL wrap_addr_ack: got %b want 0", a); end
    for (int i = 0; i < 17; i++) begin
      send_byte(8'(i), a);
      model_write(8'(i));
      checks++;
      if (a !== 1'b0) begin errors++; $display("FAIL wrap_data_ack[%0d]: got %b want 0", i, a); end
    end
    bus_stop();
    read_txn(3, a, got, r);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL wrap_rd[%0d]: got %h, scoreboard empty", i, got[8*i +: 8]);
      end else begin
        exp = exp_q.pop_front();
        if (got[8*i +: 8] !== exp) begin
          errors++; $display("FAIL wrap_rd[%0d]: got %h want %h", i, got[8*i +: 8], exp);
        end
      end
    end
  endtask

  task automatic test_abort();
    logic a;
    logic s;
    logic r;
    logic [31:0] got;
    logic [7:0] exp;
    logic [7:0] pat;
    pat = 8'hC3;
    bus_start();
    send_byte(ADDR_W, a);
    checks++;
    if (a !== 1'b0) begin errors++; $display("FAIL abort_addr_ack: got %b want 0", a); end
    for (int i = 7; i >= 3; i--) clk_bit(pat[i], s);
    bus_stop();
    for (int i = 7; i >= 0; i--) clk_bit(ADDR_W[i], s);
    clk_bit(1'b1, s);
    checks++;
    if (s !== 1'b1) begin errors++; $display("FAIL abort_idle: got %b want 1", s); end
    read_txn(1, a, got, r);
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL abort_mem: got %h, scoreboard empty", got[7:0]);
    end else begin
      exp = exp_q.pop_front();
      if (got[7:0] !== exp) begin errors++; $display("FAIL abort_mem: got %h want %h", got[7:0], exp); end
    end
  endtask

  task automatic test_reset_mid_read();
    logic a;
    logic s;
    logic r;
    logic [31:0] got;
    logic [7:0] exp;
    bus_start();
    send_byte(ADDR_R, a);
    checks++;
    if (a !== 1'b0) begin errors++; $display("FAIL midrd_addr_ack: got %b want 0", a); end
    exp_q.push_back(model_mem[mptr]);
    exp = exp_q.pop_front();
    for (int i = 7; i >= 6; i--) begin
      clk_bit(1'b1, s);
      checks++;
      if (s !== exp[i]) begin errors++; $display("FAIL midrd_bit[%0d]: got %b want %b", i, s, exp[i]); end
    end
    checks++;
    if (sda_bus !== exp[5]) begin errors++; $display("FAIL midrd_drive: got %b want %b", sda_bus, exp[5]); end
    rst = 1'b0;
    #5;
    checks++;
    if (sda_bus !== 1'b1) begin errors++; $display("FAIL midrd_reset_release: got %b want 1", sda_bus); end
    #10 rst = 1'b1;
    #10;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    read_txn(1, a, got, r);
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL midrd_cleared: got %h, scoreboard empty", got[7:0]);
    end else begin
      exp = exp_q.pop_front();
      if (got[7:0] !== exp) begin errors++; $display("FAIL midrd_cleared: got %h want %h", got[7:0], exp); end
    end
  endtask

  task automatic test_back_to_back();
    logic a;
    logic r;
    logic [3:0] dk;
    logic [31:0] data;
    logic [31:0] got;
    logic [7:0] exp;
    data = $urandom();
    write_txn(3, data, a, dk);
    checks++;
    if ({a, dk[2:0]} !== 4'b0000) begin errors++; $display("FAIL b2b_acks: got %b want 0000", {a, dk[2:0]}); end
    read_txn(3, a, got, r);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL b2b_rd[%0d]: got %h, scoreboard empty", i, got[8*i +: 8]);
      end else begin
        exp = exp_q.pop_front();
        if (got[8*i +: 8] !== exp) begin
          errors++; $display("FAIL b2b_rd[%0d]: got %h want %h", i, got[8*i +: 8], exp);
        end
      end
    end
    checks++;
    if (r !== 1'b1) begin errors++; $display("FAIL b2b_release: got %b want 1", r); end
  endtask

  initial begin
    scl    = 1'b0;
    rst    = 1'b0;
    m_low  = 1'b0;
    checks = 0;
    errors = 0;
    mptr   = 0;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    test_reset();
    test_addr_ack();
    test_write_read();
    test_addr_mismatch();
    test_wrap();
    test_abort();
    test_reset_mid_read();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave_ctrl.md
Name: i2c_slave_ctrl

Overview:
- I2C target (slave) with a 7-bit address and a small internal byte memory.
- Detects START/STOP, matches the address and ACKs it.
- Write transfers store bytes into the memory; read transfers return them MSB-first.
- Sits on the chip-level I2C pins; SCL is the only clock, with no separate system clock.

Parameters:
- SLAVE_ADDR, 7'h55, 7-bit device address matched after START.
- MEM_DEPTH, 16, number of 8-bit memory words.
- MEM_AW, 4, memory pointer width; must equal clog2(MEM_DEPTH).

Ports:
- i2c_scl  input  1  serial clock; the block's only clock (both edges used).
- i2c_rst  input  1  asynchronous, active-low reset.
- i2c_sda  inout  1  serial data; driven only when the internal output enable is set, otherwise high-Z.

Behaviour:
- Timing: SDA is sampled on SCL rising edge (sda_r). SDA is also sampled on SCL falling edge (sda_f). SDA drive/enable changes only on SCL falling edge.
- START: sda_r=1 and sda_f=0 in the same SCL-high phase. Also valid as a repeated START from any state. Effect: go to ADDR, clear bit counter, ptr<=0, release SDA.
- STOP: sda_r=0 and sda_f=1 in the same SCL-high phase. Effect: go to IDLE, release SDA.
- START/STOP take priority over every other transition.
- Reset (i2c_rst=0, async):
  - state=IDLE, sda_oe=0, sda_out=1, bit counter=0, ptr=0, shift registers=0.
  - All memory words cleared to 8'h00.
  - Reset mid-transfer aborts immediately.
- States:
  - IDLE: ignore bits, wait for START.
  - ADDR: shift 8 bits MSB-first on rising edges (7 address bits then R/W).
    - After the 8th bit, if addr==SLAVE_ADDR, go to ADDR_ACK and drive SDA=0 from the next falling edge.
    - On mismatch, go to IDLE with SDA released (NACK).
  - ADDR_ACK: ACK held for one SCL period.
    - R/W=0: at the next falling edge release SDA and go to WRITE.
    - R/W=1: at the next falling edge drive bit7 of mem[ptr] and go to READ.
  - WRITE: shift 8 bits on rising edges.
    - After the 8th bit: mem[ptr]<=byte, ptr<=ptr+1 (wraps MEM_DEPTH-1→0), drive ACK (SDA=0) on the next falling edge, go to WRITE_ACK.
  - WRITE_ACK: one SCL period, then release SDA and go to WRITE.
  - READ: present mem[ptr] MSB-first, one bit per falling edge.
    - After bit0's period, release SDA on the falling edge and go to READ_ACK.
  - READ_ACK: sample master ACK on the rising edge; ptr<=ptr+1 (wrap).
    - SDA=0 (ACK): load the next byte, drive bit7 on the falling edge, go to READ.
    - SDA=1 (NACK): go to IDLE.
- Partial byte: a byte interrupted by START/STOP is discarded (no memory write, no ptr change).
- Drive: only logic 0 is actively meaningful on the bus, but the block drives sda_out whenever sda_oe=1. Nothing is driven in IDLE, ADDR or WRITE data bits.
- Write/read pairing: ptr resets to 0 at every START, so a read after a write returns the written bytes from word 0.

Decomposition:
- Shared package i2c_slave_pkg holds:
  - state enum (IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK);
  - default SLAVE_ADDR;
  - ACK=1'b0 / NACK=1'b1 constants.
- One sub-module, i2c_slave_mem: MEM_DEPTH×8 register file with synchronous write on SCL rising, combinational read, and async active-low clear.
- FSM, shift registers and START/STOP detection stay in the top.

Test Plan:
- Reset: i2c_rst=0 for 15 ns, then released → SDA high-Z; no ACK while master sends bits without START.
- Address ACK: START, then 1010101+W → slave drives SDA=0 during the 9th SCL period, then releases.
- Write then read: write 8'hA5, repeated START, 1010101+R, master NACK → slave returns 10100101 on 8 falling edges, then goes IDLE with SDA released.
- Address mismatch: START, then 1010100+W → no ACK (SDA stays released); subsequent bits ignored until the next START.
- Multi-byte/wrap: write 17 bytes 8'h00..8'h10 (address 8'h10 is the 17th) → mem[0]=8'h10, mem[1]=8'h01; read with ACKs returns 8'h10, 8'h01, ….
- Abort: STOP after 5 data bits of a write → memory unchanged and state IDLE. Repeating with reset asserted mid-read → SDA released immediately.
